// File: rtl/ram_dp_sync.sv
//------------------------------------------------------------------------------
// Module      : ram_dp_sync
// Description : Two-read/one-write synchronous RAM with registered reads,
//               write-first forwarding and a post-reset clear sequencer.
//               Optional byte write enables: define RAMDP_BYTE_WR_EN.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module ram_dp_sync #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 9
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] d_in,
`ifdef RAMDP_BYTE_WR_EN
   input  logic [DATA_W/8-1:0] wr_be,
`endif
   input  logic              rd_en_a,
   input  logic [ADDR_W-1:0] rd_addr_a,
   output logic [DATA_W-1:0] d_out_a,
   output logic              rd_valid_a,
   input  logic              rd_en_b,
   input  logic [ADDR_W-1:0] rd_addr_b,
   output logic [DATA_W-1:0] d_out_b,
   output logic              rd_valid_b,
   output logic              busy
);

   localparam int              DEPTH       = 2**ADDR_W;
   localparam logic [ADDR_W-1:0] C_LAST_ADDR = {ADDR_W{1'b1}};

   typedef enum logic [0:0] {
      CLEAR = 1'b0,
      IDLE  = 1'b1
   } state_t;

   state_t              r_state;
   state_t              w_state_next;
   logic [ADDR_W-1:0]   r_clr_cnt;
   logic [ADDR_W-1:0]   w_clr_cnt_next;
   logic [DATA_W-1:0]   r_mem [DEPTH];
   logic [DATA_W-1:0]   w_bit_mask;
   logic [DATA_W-1:0]   w_wr_word;
   logic                w_idle;

`ifdef RAMDP_BYTE_WR_EN
   genvar k;
   generate
      for (k = 0; k < DATA_W/8; k++) begin : g_byte_mask
         assign w_bit_mask[k*8 +: 8] = {8{wr_be[k]}};
      end
   endgenerate
`else
   assign w_bit_mask = {DATA_W{1'b1}};
`endif

   // Merged word seen by both the array write and the collision forwarding path
   assign w_wr_word = (d_in & w_bit_mask) | (r_mem[wr_addr] & ~w_bit_mask);
   assign w_idle    = (r_state == IDLE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= CLEAR;
         r_clr_cnt <= '0;
      end else begin
         r_state   <= w_state_next;
         r_clr_cnt <= w_clr_cnt_next;
      end
   end

   always_comb begin
      w_state_next   = r_state;
      w_clr_cnt_next = r_clr_cnt;
      case (r_state)
         CLEAR: begin
            if (r_clr_cnt == C_LAST_ADDR) begin
               w_state_next = IDLE;
            end else begin
               w_clr_cnt_next = r_clr_cnt + 1'b1;
            end
         end
         IDLE:    w_state_next = IDLE;
         default: w_state_next = CLEAR;
      endcase
   end

   // Array has no reset; it is zeroed by the sequencer instead
   always_ff @(posedge clk) begin
      if (!w_idle) begin
         r_mem[r_clr_cnt] <= '0;
      end else if (wr) begin
         r_mem[wr_addr] <= w_wr_word;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         d_out_a    <= '0;
         d_out_b    <= '0;
         rd_valid_a <= 1'b0;
         rd_valid_b <= 1'b0;
      end else begin
         rd_valid_a <= w_idle && rd_en_a;
         rd_valid_b <= w_idle && rd_en_b;
         if (w_idle && rd_en_a) begin
            d_out_a <= (wr && (rd_addr_a == wr_addr)) ? w_wr_word : r_mem[rd_addr_a];
         end
         if (w_idle && rd_en_b) begin
            d_out_b <= (wr && (rd_addr_b == wr_addr)) ? w_wr_word : r_mem[rd_addr_b];
         end
      end
   end

   assign busy = ~w_idle;

endmodule

`default_nettype wire

// File: tb/tb_ram_dp_sync.sv
//------------------------------------------------------------------------------
// Module      : tb_ram_dp_sync
// Description : Self-checking bench for ram_dp_sync against an array model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_ram_dp_sync;

   localparam int DW    = 16;
   localparam int AW    = 9;
   localparam int DEPTH = 512;

   logic          clk = 1'b0;
   logic          reset;
   logic          wr;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] d_in;
   logic [1:0]    wr_be;
   logic          rd_en_a, rd_en_b;
   logic [AW-1:0] rd_addr_a, rd_addr_b;
   logic [DW-1:0] d_out_a, d_out_b;
   logic          rd_valid_a, rd_valid_b;
   logic          busy;

   int n_total = 0;
   int n_bad   = 0;

   logic [DW-1:0] mm [DEPTH];
   logic [DW-1:0] exp_a, exp_b;

   always #5 clk = ~clk;

   ram_dp_sync #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .clk        (clk),
      .reset      (reset),
      .wr         (wr),
      .wr_addr    (wr_addr),
      .d_in       (d_in),
`ifdef RAMDP_BYTE_WR_EN
      .wr_be      (wr_be),
`endif
      .rd_en_a    (rd_en_a),
      .rd_addr_a  (rd_addr_a),
      .d_out_a    (d_out_a),
      .rd_valid_a (rd_valid_a),
      .rd_en_b    (rd_en_b),
      .rd_addr_b  (rd_addr_b),
      .d_out_b    (d_out_b),
      .rd_valid_b (rd_valid_b),
      .busy       (busy)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) mm[i] = '0;
      exp_a = '0;
      exp_b = '0;
   endtask

   function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                           input logic [1:0] be);
      logic [DW-1:0] r;
      r = old;
      for (int k = 0; k < 2; k++) if (be[k]) r[k*8 +: 8] = nw[k*8 +: 8];
      return r;
   endfunction

   // One idle-state cycle: drive, predict from the model, clock, compare.
   task automatic do_cycle(input logic w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                           input logic [1:0] be, input logic ea, input logic [AW-1:0] aa,
                           input logic eb, input logic [AW-1:0] ab);
      logic [1:0]    be_eff;
      logic [DW-1:0] new_word;
      @(negedge clk);
      wr = w; wr_addr = wa; d_in = wd; wr_be = be;
      rd_en_a = ea; rd_addr_a = aa; rd_en_b = eb; rd_addr_b = ab;
`ifdef RAMDP_BYTE_WR_EN
      be_eff = be;
`else
      be_eff = 2'b11;
`endif
      new_word = merge(mm[wa], wd, be_eff);
      if (ea) exp_a = (w && aa == wa) ? new_word : mm[aa];
      if (eb) exp_b = (w && ab == wa) ? new_word : mm[ab];
      if (w) mm[wa] = new_word;
      @(posedge clk);
      #1;
      check_eq("d_out_a", d_out_a, exp_a);
      check_eq("d_out_b", d_out_b, exp_b);
      check_eq("rd_valid_a", rd_valid_a, ea);
      check_eq("rd_valid_b", rd_valid_b, eb);
      check_eq("busy_idle", busy, 1'b0);
   endtask

   // Accesses presented during the clear sequence; they must all be ignored.
   task automatic drive_junk();
      wr = 1'b1; wr_addr = 9'd5; d_in = 16'h5555; wr_be = 2'b11;
      rd_en_a = 1'b1; rd_addr_a = 9'd5; rd_en_b = 1'b1; rd_addr_b = 9'h100;
   endtask

   task automatic wait_clear(output int n);
      int viol;
      viol = 0;
      n = 0;
      while (n < 2000) begin
         @(posedge clk);
         #1;
         n++;
         if (busy !== 1'b1) break;
         if (rd_valid_a !== 1'b0 || rd_valid_b !== 1'b0 || d_out_a !== '0 || d_out_b !== '0)
            viol++;
      end
      check_eq("clear_outputs_quiet", viol, 0);
   endtask

   initial begin
      int n;
      reset = 1'b0;
      drive_junk();
      model_reset();

      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_busy", busy, 1'b1);
      check_eq("rst_d_out_a", d_out_a, 16'h0);
      check_eq("rst_d_out_b", d_out_b, 16'h0);
      check_eq("rst_valid_a", rd_valid_a, 1'b0);
      check_eq("rst_valid_b", rd_valid_b, 1'b0);

      @(negedge clk);
      reset = 1'b1;
      wait_clear(n);
      check_eq("clear_len", n, DEPTH);

      do_cycle(0, 0, 0, 2'b00, 1, 9'd0, 1, 9'd255);
      check_eq("clr_addr0", d_out_a, 16'h0);
      check_eq("clr_addr255", d_out_b, 16'h0);
      do_cycle(0, 0, 0, 2'b00, 1, 9'd511, 1, 9'd5);
      check_eq("clr_addr511", d_out_a, 16'h0);
      check_eq("wr_during_clear", d_out_b, 16'h0);
      check_eq("wr_during_clear_valid", rd_valid_b, 1'b1);

      do_cycle(1, 9'h1F3, 16'hA5A5, 2'b11, 0, 0, 0, 0);
      do_cycle(0, 0, 0, 2'b00, 1, 9'h1F3, 1, 9'h1F3);
      check_eq("basic_a", d_out_a, 16'hA5A5);
      check_eq("basic_b", d_out_b, 16'hA5A5);

      do_cycle(1, 9'h010, 16'h1111, 2'b11, 0, 0, 0, 0);
      do_cycle(1, 9'h010, 16'h2222, 2'b11, 1, 9'h010, 1, 9'h011);
      check_eq("collision_fwd_a", d_out_a, 16'h2222);
      do_cycle(0, 0, 0, 2'b00, 0, 0, 1, 9'h010);
      check_eq("after_collision_b", d_out_b, 16'h2222);

      do_cycle(1, 9'h020, 16'hBEEF, 2'b11, 0, 0, 0, 0);
      do_cycle(0, 0, 0, 2'b00, 1, 9'h020, 0, 0);
      check_eq("hold_first", d_out_a, 16'hBEEF);
      for (int i = 0; i < 4; i++) begin
         do_cycle(1, 9'h020, 16'h0F0F, 2'b11, 0, 9'h020, 0, 0);
         check_eq("hold_data", d_out_a, 16'hBEEF);
         check_eq("hold_valid", rd_valid_a, 1'b0);
      end

`ifdef RAMDP_BYTE_WR_EN
      do_cycle(1, 9'd7, 16'h1234, 2'b11, 0, 0, 0, 0);
      do_cycle(1, 9'd7, 16'hABCD, 2'b01, 0, 0, 0, 0);
      do_cycle(0, 0, 0, 2'b00, 1, 9'd7, 0, 0);
      check_eq("be_read", d_out_a, 16'h12CD);
      do_cycle(1, 9'd7, 16'h1234, 2'b11, 0, 0, 0, 0);
      do_cycle(1, 9'd7, 16'hABCD, 2'b01, 1, 9'd7, 1, 9'd7);
      check_eq("be_fwd_a", d_out_a, 16'h12CD);
      check_eq("be_fwd_b", d_out_b, 16'h12CD);
      do_cycle(1, 9'd7, 16'hFFFF, 2'b00, 1, 9'd7, 0, 0);
      check_eq("be_zero_noop", d_out_a, 16'h12CD);
`endif

      for (int i = 0; i < 400; i++) begin
         do_cycle(1'($urandom_range(0, 1)), 9'($urandom_range(0, 15)), 16'($urandom),
                  2'($urandom), 1'($urandom_range(0, 2) != 0), 9'($urandom_range(0, 15)),
                  1'($urandom_range(0, 2) != 0), 9'($urandom_range(0, 15)));
      end

      do_cycle(1, 9'h100, 16'h7777, 2'b11, 0, 0, 0, 0);
      @(negedge clk);
      reset = 1'b0;
      drive_junk();
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      repeat (300) @(posedge clk);
      #1;
      check_eq("midclear_busy", busy, 1'b1);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check_eq("midclear_rst_busy", busy, 1'b1);
      check_eq("midclear_rst_valid", rd_valid_a, 1'b0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      wait_clear(n);
      check_eq("reclear_len", n, DEPTH);
      model_reset();
      do_cycle(0, 0, 0, 2'b00, 1, 9'h100, 1, 9'h1F3);
      check_eq("reclear_word_a", d_out_a, 16'h0);
      check_eq("reclear_word_b", d_out_b, 16'h0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/ram_dp_sync.md
# ram_dp_sync

Parametrised two-read/one-write synchronous RAM. It is the generalised successor to the fixed 512×16 dual-read RAM and replaces the hand-built hierarchy of banks, demux and muxes with one configurable array. It adds registered reads with a valid strobe, write-first forwarding on address collision, and a hardware clear sequencer that zeroes every word after reset. It sits between the register-file/datapath logic and the wider memory subsystem.

## Interface
Parameters:
- DATA_W, 16, word width in bits (≥1; multiple of 8 when RAMDP_BYTE_WR_EN is defined)
- ADDR_W, 9, address width; DEPTH = 2**ADDR_W words

Ports:
- clk  in  1  single clock, rising-edge
- reset  in  1  asynchronous, active-low reset (0 = in reset)
- wr  in  1  write request
- wr_addr  in  ADDR_W  write address
- d_in  in  DATA_W  write data
- wr_be  in  DATA_W/8  byte write enables (present only with RAMDP_BYTE_WR_EN)
- rd_en_a  in  1  read request, port A
- rd_addr_a  in  ADDR_W  read address, port A
- d_out_a  out  DATA_W  registered read data, port A
- rd_valid_a  out  1  d_out_a updated this cycle
- rd_en_b, rd_addr_b, d_out_b, rd_valid_b: same as port A, for port B
- busy  out  1  clear sequencer active; writes and reads are not accepted

## Operation
- FSM states: CLEAR, IDLE.
- Reset asserted (reset=0): state=CLEAR, clear counter=0, busy=1, d_out_a/b=0, rd_valid_a/b=0. Array contents are not touched asynchronously.
- CLEAR: each cycle writes 0 to mem[counter] and increments counter. When counter=DEPTH-1 is written, the next state is IDLE and busy=0 from that edge. The counter is ADDR_W bits wide and does not wrap.
- CLEAR: wr, rd_en_a and rd_en_b are ignored. rd_valid stays 0 and d_out holds 0.
- IDLE, write: if wr=1 at a rising edge, mem[wr_addr] ← d_in.
- IDLE, read: if rd_en_x=1 at a rising edge, d_out_x ← mem[rd_addr_x] and rd_valid_x=1 for one cycle. If rd_en_x=0, d_out_x holds its last value and rd_valid_x=0.
- Collision: if wr=1 and rd_addr_x==wr_addr in the same cycle, d_out_x returns the new d_in (write-first). This applies to both ports independently.
- Both ports may read the same address in the same cycle; both return identical data.
- Reset asserted mid-CLEAR or mid-operation: the sequencer restarts at address 0 and all DEPTH words are re-cleared.

## Timing
- Read latency: 1 cycle. Address and rd_en are sampled at edge N; data and rd_valid are visible after edge N and remain valid until edge N+1.
- Write latency: 1 cycle. A read issued at edge N+1 to an address written at edge N returns the new data. A read at edge N returns the new data through the forwarding path.
- Clear duration: exactly DEPTH cycles after reset deassertion. This is 512 cycles at the defaults. busy falls after the DEPTH-th rising edge.
- The first write or read is accepted on the first edge where busy=0 was sampled.
- No combinational path from any input to any output.

## Configuration
- RAMDP_BYTE_WR_EN defined:
  - wr_be port exists.
  - A write updates only bytes k with wr_be[k]=1 and leaves other bytes unchanged.
  - Forwarding merges per byte: enabled bytes come from d_in, other bytes from the stored word.
  - wr=1 with wr_be=0 is a no-op.
- RAMDP_BYTE_WR_EN undefined:
  - No wr_be port.
  - Every write replaces the full word.

## Test plan
- Clear sequence:
  - Stimulus: hold reset=0 for 3 cycles, then release.
  - Required: busy=1 for exactly 512 cycles, then 0. Reads of addresses 0, 255 and 511 each return 0x0000 with rd_valid=1.
- Basic write/read:
  - Stimulus: write 0xA5A5 to address 0x1F3, then read it on port A and port B together.
  - Required: on the next cycle both d_out ports show 0xA5A5 and both rd_valid are 1.
- Collision forwarding:
  - Stimulus: address 0x010 holds 0x1111. In the same cycle, write 0x2222 to 0x010 and read 0x010 on port A.
  - Required: d_out_a=0x2222.
- Hold behaviour and ignored accesses during clear:
  - Stimulus: after a read returns 0xBEEF, drop rd_en_a for 4 cycles.
  - Required: d_out_a stays 0xBEEF and rd_valid_a=0 throughout.
  - Stimulus: issue wr=1 to address 5 during CLEAR.
  - Required: a later read of address 5 returns 0.
- Reset mid-clear:
  - Stimulus: assert reset at clear cycle 300, then release.
  - Required: busy stays high for a full 512 more cycles. A word written before reset reads 0.
- Byte enables (RAMDP_BYTE_WR_EN defined):
  - Stimulus: address 7 holds 0x1234. Write 0xABCD with wr_be=2'b01.
  - Required: read returns 0x12CD. The same write issued with a same-cycle read forwards 0x12CD.
